execute_stage_md: RTL and testbench

Parametrised execute stage for the five-stage RISC-V pipeline with branch prediction. It takes already-forwarded operands from the hazard muxes and resolves branches, jumps and `jalr` against the fetch-stage prediction. It adds an iterative RV32M multiply/divide unit that stalls the pipeline while busy. Results go to the E/M pipeline register, and saturating performance counters track branches and mispredictions.

---
 rtl/execute_stage_md.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_execute_stage_md.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_md.sv
// Execute stage: branch/jump/jalr resolution against the fetch prediction, an
// iterative RV32M multiply/divide unit that stalls E while busy, and the E/M register.
module execute_stage_md #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_e,
    input  logic              flush_e,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    input  logic [XLEN-1:0]   alu_result_e,
    input  logic [XLEN-1:0]   pc_e,
    input  logic [XLEN-1:0]   imm_e,
    input  logic [XLEN-1:0]   pc_plus4_e,
    input  logic [2:0]        funct3_e,
    input  logic              is_md_e,
    input  logic              branch_e,
    input  logic              jump_e,
    input  logic              jalr_e,
    input  logic              predict_taken_e,
    input  logic [RA_W-1:0]   rd_e,
    input  logic              regwrite_e,
    input  logic              memwrite_e,
    input  logic [1:0]        resultsrc_e,
    output logic              stall_e,
    output logic              redirect_e,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              update_en,
    output logic              actual_taken,
    output logic              valid_m,
    output logic              regwrite_m,
    output logic              memwrite_m,
    output logic [XLEN-1:0]   result_m,
    output logic [XLEN-1:0]   write_data_m,
    output logic [XLEN-1:0]   pc_plus4_m,
    output logic [RA_W-1:0]   rd_m,
    output logic [1:0]        resultsrc_m,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CW-1:0]     r_count;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic [2:0]        r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_mispredict_cnt;

    logic              w_live;
    logic              w_md_req;
    logic              w_br_live;
    logic              w_cond;
    logic              w_taken;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_md_result;
    logic [XLEN-1:0]   w_result_sel;

    // Reset also gates the combinational outputs so everything reads 0 while rst is low.
    assign w_live    = rst & valid_e & ~flush_e;
    assign w_md_req  = w_live & is_md_e;
    assign stall_e   = w_md_req & (r_state != S_DONE);
    assign w_br_live = w_live & ~stall_e;

    always_comb begin
        w_cond = 1'b0;
        case (funct3_e)
            3'd0:    w_cond = (src_a == src_b);
            3'd1:    w_cond = (src_a != src_b);
            3'd4:    w_cond = ($signed(src_a) <  $signed(src_b));
            3'd5:    w_cond = ($signed(src_a) >= $signed(src_b));
            3'd6:    w_cond = (src_a <  src_b);
            3'd7:    w_cond = (src_a >= src_b);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken      = jump_e | jalr_e | (branch_e & w_cond);
    assign actual_taken = w_br_live & w_taken;
    assign update_en    = w_br_live & (branch_e | jump_e);
    assign redirect_e   = w_br_live & (jalr_e | ((branch_e | jump_e) & (predict_taken_e != w_taken)));

    always_comb begin
        redirect_pc = '0;
        if (redirect_e) begin
            if (jalr_e) begin
                redirect_pc = (src_a + imm_e) & ~{{(XLEN-1){1'b0}}, 1'b1};
            end else if (w_taken) begin
                redirect_pc = pc_e + imm_e;
            end else begin
                redirect_pc = pc_plus4_e;
            end
        end
    end

    // Operand signedness per M op: MUL/MULH/DIV/REM signed, MULHSU signed x unsigned.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (funct3_e)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            3'd2:    w_a_signed = 1'b1;
            default: ;
        endcase
    end

    assign w_a_neg    = w_a_signed & src_a[XLEN-1];
    assign w_b_neg    = w_b_signed & src_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -src_a : src_a;
    assign w_b_mag    = w_b_neg ? -src_b : src_b;
    assign w_div_zero = funct3_e[2] & (src_b == '0);
    assign w_div_ovf  = funct3_e[2] & ~funct3_e[0] & (src_a == MOST_NEG) & (&src_b);

    // Shift-add multiply: {hi,lo} shifts right, lo starts as the multiplier.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    // Restoring divide: lo holds the dividend and fills with quotient bits.
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_diff  = w_div_shift[XLEN-1:0] - r_b;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_md_req) w_state_next = (w_div_zero | w_div_ovf) ? S_DONE : S_BUSY;
            S_BUSY:  if (r_count == CW'(XLEN-1)) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush_e) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md_req) begin
                        r_op    <= funct3_e;
                        r_count <= '0;
                        r_b     <= w_b_mag;
                        // Fast-path results are parked so the normal sign fix is a no-op.
                        if (w_div_zero) begin
                            r_hi    <= src_a;
                            r_lo    <= '1;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_div_ovf) begin
                            r_hi    <= '0;
                            r_lo    <= src_a;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_hi    <= '0;
                            r_lo    <= w_a_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                S_BUSY: begin
                    r_count <= r_count + CW'(1);
                    if (r_op[2]) begin
                        r_hi <= w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_div_ge};
                    end else begin
                        r_hi <= w_mul_sum[XLEN:1];
                        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quot     = r_neg_q ? -r_lo : r_lo;
    assign w_rem      = r_neg_r ? -r_hi : r_hi;

    always_comb begin
        w_md_result = w_rem;
        case (r_op)
            3'd0:             w_md_result = w_prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_md_result = w_prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       w_md_result = w_quot;
            default:          w_md_result = w_rem;
        endcase
    end

    assign w_result_sel = (jump_e | jalr_e) ? pc_plus4_e :
                          (is_md_e ? w_md_result : alu_result_e);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_m      <= 1'b0;
            regwrite_m   <= 1'b0;
            memwrite_m   <= 1'b0;
            result_m     <= '0;
            write_data_m <= '0;
            pc_plus4_m   <= '0;
            rd_m         <= '0;
            resultsrc_m  <= '0;
        end else if (w_br_live) begin
            valid_m      <= 1'b1;
            regwrite_m   <= regwrite_e;
            memwrite_m   <= memwrite_e;
            result_m     <= w_result_sel;
            write_data_m <= src_b;
            pc_plus4_m   <= pc_plus4_e;
            rd_m         <= rd_e;
            resultsrc_m  <= resultsrc_e;
        end else begin
            valid_m      <= 1'b0;
            regwrite_m   <= 1'b0;
            memwrite_m   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (update_en && !(&r_branch_cnt)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (redirect_e && !jalr_e && !(&r_mispredict_cnt)) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
            end
        end
    end

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_execute_stage_md.sv
// Randomised bench for execute_stage_md: an instruction-level reference model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_execute_stage_md;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              valid_e, flush_e;
    logic [XLEN-1:0]   src_a, src_b, alu_result_e, pc_e, imm_e, pc_plus4_e;
    logic [2:0]        funct3_e;
    logic              is_md_e, branch_e, jump_e, jalr_e, predict_taken_e;
    logic [RA_W-1:0]   rd_e;
    logic              regwrite_e, memwrite_e;
    logic [1:0]        resultsrc_e;
    logic              stall_e, redirect_e, update_en, actual_taken;
    logic [XLEN-1:0]   redirect_pc;
    logic              valid_m, regwrite_m, memwrite_m;
    logic [XLEN-1:0]   result_m, write_data_m, pc_plus4_m;
    logic [RA_W-1:0]   rd_m;
    logic [1:0]        resultsrc_m;
    logic [CNT_W-1:0]  branch_cnt, mispredict_cnt;

    int errors = 0;
    int checks = 0;
    int stall_seen = 0;
    int cycles = 0;

    execute_stage_md #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e(flush_e),
        .src_a(src_a), .src_b(src_b), .alu_result_e(alu_result_e),
        .pc_e(pc_e), .imm_e(imm_e), .pc_plus4_e(pc_plus4_e), .funct3_e(funct3_e),
        .is_md_e(is_md_e), .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e),
        .predict_taken_e(predict_taken_e), .rd_e(rd_e), .regwrite_e(regwrite_e),
        .memwrite_e(memwrite_e), .resultsrc_e(resultsrc_e), .stall_e(stall_e),
        .redirect_e(redirect_e), .redirect_pc(redirect_pc), .update_en(update_en),
        .actual_taken(actual_taken), .valid_m(valid_m), .regwrite_m(regwrite_m),
        .memwrite_m(memwrite_m), .result_m(result_m), .write_data_m(write_data_m),
        .pc_plus4_m(pc_plus4_m), .rd_m(rd_m), .resultsrc_m(resultsrc_m),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic for the M ops, straight from the ISA definitions.
    function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles the unit stalls E for a given op.
    function automatic int md_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return XLEN + 1;
    endfunction

    function automatic logic br_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Compare process: model state plus per-cycle checks at the falling edge.
    initial begin
        logic        live, x_stall, x_red, x_act, x_upd, x_taken;
        logic [31:0] x_pc;
        logic        e_valid, e_regwrite, e_memwrite;
        logic [31:0] e_result, e_wdata, e_pcp4;
        logic [4:0]  e_rd;
        logic [1:0]  e_rsrc;
        int          e_bcnt, e_mcnt;
        logic        md_active;
        int          md_age, md_n;
        {e_valid, e_regwrite, e_memwrite} = '0;
        e_result = '0; e_wdata = '0; e_pcp4 = '0; e_rd = '0; e_rsrc = '0;
        e_bcnt = 0; e_mcnt = 0; md_active = 1'b0; md_age = 0; md_n = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (cycles > 50000) begin
                $display("FAIL watchdog: got %0d cycles expected under 50000", cycles);
                $fatal(1);
            end
            if (stall_e === 1'b1) stall_seen++;
            if (!rst) begin
                chk("rst_stall", 32'(stall_e), 0);
                chk("rst_redirect", 32'(redirect_e), 0);
                chk("rst_redirect_pc", redirect_pc, 0);
                chk("rst_update", 32'(update_en), 0);
                chk("rst_actual", 32'(actual_taken), 0);
                chk("rst_ctrl_m", 32'({valid_m, regwrite_m, memwrite_m}), 0);
                chk("rst_result_m", result_m, 0);
                chk("rst_wdata_m", write_data_m, 0);
                chk("rst_pcp4_m", pc_plus4_m, 0);
                chk("rst_rd_rsrc_m", 32'({rd_m, resultsrc_m}), 0);
                chk("rst_counters", 32'({branch_cnt, mispredict_cnt}), 0);
                {e_valid, e_regwrite, e_memwrite} = '0;
                e_result = '0; e_wdata = '0; e_pcp4 = '0; e_rd = '0; e_rsrc = '0;
                e_bcnt = 0; e_mcnt = 0; md_active = 1'b0;
            end else begin
                live    = valid_e && !flush_e;
                x_stall = 1'b0;
                if (live && is_md_e) begin
                    if (!md_active) begin
                        md_active = 1'b1;
                        md_age    = 0;
                        md_n      = md_lat(funct3_e, src_a, src_b);
                    end
                    x_stall = (md_age < md_n);
                end else begin
                    md_active = 1'b0;
                end
                x_taken = jump_e || jalr_e || (branch_e && br_cond(funct3_e, src_a, src_b));
                x_red = 1'b0; x_act = 1'b0; x_upd = 1'b0; x_pc = '0;
                if (live && !x_stall) begin
                    x_act = x_taken;
                    x_upd = branch_e || jump_e;
                    x_red = jalr_e || ((branch_e || jump_e) && (predict_taken_e != x_taken));
                    if (jalr_e)       x_pc = (src_a + imm_e) & 32'hFFFF_FFFE;
                    else if (x_taken) x_pc = pc_e + imm_e;
                    else              x_pc = pc_plus4_e;
                end
                chk("stall_e", 32'(stall_e), 32'(x_stall));
                chk("redirect_e", 32'(redirect_e), 32'(x_red));
                chk("actual_taken", 32'(actual_taken), 32'(x_act));
                chk("update_en", 32'(update_en), 32'(x_upd));
                if (x_red) chk("redirect_pc", redirect_pc, x_pc);
                else if (!(live && !x_stall)) chk("redirect_pc_idle", redirect_pc, 0);
                chk("valid_m", 32'(valid_m), 32'(e_valid));
                chk("regwrite_m", 32'(regwrite_m), 32'(e_regwrite));
                chk("memwrite_m", 32'(memwrite_m), 32'(e_memwrite));
                chk("result_m", result_m, e_result);
                chk("write_data_m", write_data_m, e_wdata);
                chk("pc_plus4_m", pc_plus4_m, e_pcp4);
                chk("rd_m", 32'(rd_m), 32'(e_rd));
                chk("resultsrc_m", 32'(resultsrc_m), 32'(e_rsrc));
                chk("branch_cnt", 32'(branch_cnt), e_bcnt);
                chk("mispredict_cnt", 32'(mispredict_cnt), e_mcnt);
                // Advance the model to what the coming edge must produce.
                if (live && !x_stall) begin
                    e_valid = 1'b1; e_regwrite = regwrite_e; e_memwrite = memwrite_e;
                    if (jump_e || jalr_e) e_result = pc_plus4_e;
                    else if (is_md_e)     e_result = md_ref(funct3_e, src_a, src_b);
                    else                  e_result = alu_result_e;
                    e_wdata = src_b; e_pcp4 = pc_plus4_e; e_rd = rd_e; e_rsrc = resultsrc_e;
                end else begin
                    {e_valid, e_regwrite, e_memwrite} = '0;
                end
                if (x_upd && e_bcnt < CMAX) e_bcnt++;
                if (x_red && !jalr_e && e_mcnt < CMAX) e_mcnt++;
                if (md_active) begin
                    if (x_stall) md_age++;
                    else md_active = 1'b0;
                end
            end
        end
    end

    task automatic clear_inputs();
        valid_e = 0; flush_e = 0; src_a = 0; src_b = 0; alu_result_e = 0;
        pc_e = 0; imm_e = 0; pc_plus4_e = 0; funct3_e = 0; is_md_e = 0;
        branch_e = 0; jump_e = 0; jalr_e = 0; predict_taken_e = 0;
        rd_e = 0; regwrite_e = 0; memwrite_e = 0; resultsrc_e = 0;
    endtask

    task automatic start_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic issue_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        start_cycle();
        valid_e = 1; is_md_e = 1; funct3_e = op; src_a = a; src_b = b;
        regwrite_e = 1; rd_e = 5'($urandom); alu_result_e = $urandom;
        pc_e = 32'h200; pc_plus4_e = 32'h204;
        n = md_lat(op, a, b) + 1;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic md_directed(input string nm, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
        int s0;
        s0 = stall_seen;
        issue_md(op, a, b);
        start_cycle();
        @(negedge clk);
        $display("tx %s op=%0d a=%h b=%h result_m=%h stall_cycles=%0d", nm, op, a, b, result_m, stall_seen - s0);
        chk({nm, "_result"}, result_m, exp_res);
        chk({nm, "_valid_m"}, 32'(valid_m), 1);
        chk({nm, "_stall_cycles"}, stall_seen - s0, exp_stall);
    endtask

    task automatic random_tx(input int idx);
        int cls, n;
        start_cycle();
        cls = $urandom_range(0, 9);
        valid_e = 1; src_a = pick(); src_b = pick(); alu_result_e = $urandom;
        pc_e = $urandom & 32'hFFFF_FFFC; imm_e = $urandom; pc_plus4_e = pc_e + 4;
        funct3_e = 3'($urandom_range(0, 7)); rd_e = 5'($urandom);
        regwrite_e = 1'($urandom); memwrite_e = 1'($urandom);
        resultsrc_e = 2'($urandom); predict_taken_e = 1'($urandom);
        case (cls)
            3, 4: branch_e = 1;
            5: jump_e = 1;
            6: jalr_e = 1;
            7, 8: is_md_e = 1;
            9: begin
                is_md_e = 1'($urandom);
                if ($urandom_range(0, 1) == 0) valid_e = 0;
                else flush_e = 1;
            end
            default: ;
        endcase
        n = (valid_e && !flush_e && is_md_e) ? md_lat(funct3_e, src_a, src_b) + 1 : 1;
        $display("tx %0d cls=%0d f3=%0d a=%h b=%h cycles=%0d", idx, cls, funct3_e, src_a, src_b, n);
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;

        // BEQ mispredicted not-taken
        start_cycle();
        valid_e = 1; branch_e = 1; funct3_e = 3'd0; src_a = 5; src_b = 5;
        pc_e = 32'h100; imm_e = 32'h20; pc_plus4_e = 32'h104; predict_taken_e = 0;
        @(negedge clk);
        $display("tx beq redirect=%0d pc=%h taken=%0d", redirect_e, redirect_pc, actual_taken);
        chk("beq_redirect", 32'(redirect_e), 1);
        chk("beq_redirect_pc", redirect_pc, 32'h120);
        chk("beq_actual", 32'(actual_taken), 1);
        start_cycle();
        @(negedge clk);
        chk("beq_branch_cnt", 32'(branch_cnt), 1);
        chk("beq_mispredict_cnt", 32'(mispredict_cnt), 1);

        md_directed("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        md_directed("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        md_directed("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        md_directed("div_neg", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
        md_directed("rem_neg", 3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);

        // DIVU flushed in cycle 10, then a fast DIVU accepted right after
        start_cycle();
        valid_e = 1; is_md_e = 1; funct3_e = 3'd5; src_a = 32'd1000; src_b = 32'd7; regwrite_e = 1;
        repeat (10) @(posedge clk);
        #1 flush_e = 1;
        @(negedge clk);
        $display("tx divu_flush stall=%0d", stall_e);
        chk("flush_stall", 32'(stall_e), 0);
        md_directed("divu_zero", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
        md_directed("remu_zero", 3'd7, 32'd100, 32'd0, 32'd100, 1);

        // Reset in the middle of a MULHU
        start_cycle();
        valid_e = 1; is_md_e = 1; funct3_e = 3'd3; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678; regwrite_e = 1;
        repeat (5) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        $display("tx mulhu_reset stall=%0d result_m=%h", stall_e, result_m);
        chk("reset_stall", 32'(stall_e), 0);
        chk("reset_result_m", result_m, 0);
        chk("reset_branch_cnt", 32'(branch_cnt), 0);
        start_cycle();
        rst = 1;
        start_cycle();
        valid_e = 1; branch_e = 1; funct3_e = 3'd1; src_a = 3; src_b = 4;
        pc_e = 32'h300; imm_e = 32'h40; pc_plus4_e = 32'h304; predict_taken_e = 1;
        @(negedge clk);
        $display("tx bne redirect=%0d taken=%0d", redirect_e, actual_taken);
        chk("bne_redirect", 32'(redirect_e), 0);
        chk("bne_actual", 32'(actual_taken), 1);

        for (int i = 0; i < 150; i++) random_tx(i);

        // Drive counters to saturation with mispredicted jumps
        for (int i = 0; i < 20; i++) begin
            start_cycle();
            valid_e = 1; jump_e = 1; predict_taken_e = 0;
            pc_e = 32'h400 + 32'(i * 4); imm_e = 32'h80; pc_plus4_e = pc_e + 4;
            $display("tx jump %0d", i);
        end
        start_cycle();
        @(negedge clk);
        chk("sat_branch_cnt", 32'(branch_cnt), CMAX);
        chk("sat_mispredict_cnt", 32'(mispredict_cnt), CMAX);

        start_cycle();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
